alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   Registered 16-function integer ALU. Combines two WIDTH-bit operands per
//   a 4-bit opcode and produces a WIDTH-bit result plus a carry/flag bit.
//   It is a leaf datapath block: the result is registered, with one cycle of latency.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (all values below assume 8)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   A          in   WIDTH  operand A (unsigned)
//   B          in   WIDTH  operand B (unsigned)
//   alu_sel    in   4      opcode
//   alu_out    out  WIDTH  registered result
//   carry_out  out  1      registered carry/flag
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - On a clk edge with rst=1: alu_out=0, carry_out=0. This overrides all inputs.
//   - On a clk edge with rst=0: register f(A,B,alu_sel). Latency is 1 cycle.
//     There is no handshake; a new op is accepted every cycle.
//   - Outputs hold between edges. Input changes mid-cycle are not visible until the next edge.
//   - All math is unsigned, modulo 2^WIDTH.
//   - Opcodes (out / carry_out):
//     0 ADD  A+B low byte / bit 8 of 9-bit sum
//     1 SUB  A-B low byte / 1 if A<B (borrow)
//     2 MUL  low byte of A*B / 1 if high byte of 16-bit product != 0
//     3 DIV  A/B (floor) / 0. If B==0: out=8'hFF, carry=1
//     4 SHL  A<<1 / A[7]
//     5 SHR  A>>1 (logical) / A[0]
//     6 ROL  {A[6:0],A[7]} / 0
//     7 ROR  {A[0],A[7:1]} / 0
//     8 AND  A&B / 0
//     9 OR   A|B / 0
//     10 XOR A^B / 0
//     11 NOR ~(A|B) / 0
//     12 NAND ~(A&B) / 0
//     13 XNOR ~(A^B) / 0
//     14 GT  (A>B)?1:0 / 0
//     15 EQ  (A==B)?1:0 / 0
//   - Wrap-around: ADD 8'hFF+8'h01 gives out=00, carry=1. SUB 00-01 gives out=FF, carry=1.
//   - Reset mid-stream: the cycle with rst=1 yields 0/0. The next edge with rst=0 returns
//     the current op result.
// TESTING
//   - Reset: rst=1 for 1 edge with any inputs -> alu_out=00, carry_out=0.
//   - A=05, B=04, sel 1,2,3,4 on successive edges -> out=01,14,01,0A; carry=0,0,0,0.
//     Each result appears one edge after its sel.
//   - ADD overflow: A=FF, B=01, sel=0 -> out=00, carry=1.
//     SUB borrow: A=00, B=01, sel=1 -> out=FF, carry=1.
//   - MUL/DIV edges: A=10, B=10, sel=2 -> out=00, carry=1.
//     A=07, B=00, sel=3 -> out=FF, carry=1.
//   - Shift/rotate with A=81: sel4 -> 02/c1; sel5 -> 40/c1; sel6 -> 03/c0; sel7 -> C0/c0.
//   - Logic/compare with A=F0, B=3C: sel8..13 -> 30,FC,CC,03,CF,33.
//     sel14 -> 01; sel15 -> 00. With A=B=3C, sel15 -> 01.

Source files
------------

// File: rtl/alu.sv
// Registered 16-function unsigned integer ALU producing a result and a carry/flag bit.
// Latency: 1 cycle from operand/opcode sample to registered alu_out/carry_out.
// Backpressure: none; a new operation is accepted on every rising edge.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } op_e;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic               b_zero;

    logic [WIDTH-1:0]   alu_out_d, alu_out_q;
    logic               carry_d, carry_q;

    assign sum    = {1'b0, A} + {1'b0, B};
    assign diff   = A - B;
    assign prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign b_zero = (B == '0);
    // Divisor forced to 1 on B==0 so the divider never sees zero; the result is overridden anyway.
    assign quot   = A / (b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B);

    always_comb begin
        alu_out_d = '0;
        carry_d   = 1'b0;
        case (op_e'(alu_sel))
            OP_ADD: begin
                alu_out_d = sum[WIDTH-1:0];
                carry_d   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_out_d = diff;
                carry_d   = (A < B);
            end
            OP_MUL: begin
                alu_out_d = prod[WIDTH-1:0];
                carry_d   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                alu_out_d = b_zero ? {WIDTH{1'b1}} : quot;
                carry_d   = b_zero;
            end
            OP_SHL: begin
                alu_out_d = {A[WIDTH-2:0], 1'b0};
                carry_d   = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_out_d = {1'b0, A[WIDTH-1:1]};
                carry_d   = A[0];
            end
            OP_ROL:  alu_out_d = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  alu_out_d = {A[0], A[WIDTH-1:1]};
            OP_AND:  alu_out_d = A & B;
            OP_OR:   alu_out_d = A | B;
            OP_XOR:  alu_out_d = A ^ B;
            OP_NOR:  alu_out_d = ~(A | B);
            OP_NAND: alu_out_d = ~(A & B);
            OP_XNOR: alu_out_d = ~(A ^ B);
            OP_GT:   alu_out_d = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   alu_out_d = {{(WIDTH-1){1'b0}}, (A == B)};
            default: begin
                alu_out_d = '0;
                carry_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
        end
    end

    assign alu_out   = alu_out_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases from the opcode table plus randomized ops
// compared against an arithmetic reference model.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;

    int tests_run = 0;
    int tests_failed = 0;

    alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode table.
    function automatic void model(input int a, input int b, input int sel,
                                  output int out, output int c);
        logic [7:0] va, vb;
        int s;
        va = a[7:0];
        vb = b[7:0];
        out = 0;
        c = 0;
        case (sel)
            0:  begin s = a + b; out = s % 256; c = s / 256; end
            1:  begin out = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2:  begin s = a * b; out = s % 256; c = (s >= 256) ? 1 : 0; end
            3:  begin
                    if (b == 0) begin out = 255; c = 1; end
                    else        begin out = a / b; c = 0; end
                end
            4:  begin out = (a * 2) % 256; c = a / 128; end
            5:  begin out = a / 2; c = a % 2; end
            6:  out = (a * 2) % 256 + a / 128;
            7:  out = a / 2 + (a % 2) * 128;
            8:  out = int'(va & vb);
            9:  out = int'(va | vb);
            10: out = int'(va ^ vb);
            11: out = int'(8'(~(va | vb)));
            12: out = int'(8'(~(va & vb)));
            13: out = int'(8'(~(va ^ vb)));
            14: out = (a > b) ? 1 : 0;
            15: out = (a == b) ? 1 : 0;
            default: begin out = 0; c = 0; end
        endcase
    endfunction

    // Drive inputs away from the edge, then let one rising edge register them.
    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel);
        @(negedge clk);
        rst = r;
        A = a;
        B = b;
        alu_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        apply(1'b1, 8'hFF, 8'hFF, 4'd0);
        tests_run++;
        if (alu_out !== 8'h00 || carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got out=%h c=%b, want out=00 c=0", alu_out, carry_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] sels [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [7:0] exps [4] = '{8'h01, 8'h14, 8'h01, 8'h0A};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 8'h05, 8'h04, sels[i]);
            tests_run++;
            if (alu_out !== exps[i] || carry_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b sel=%0d: got out=%h c=%b, want out=%h c=0",
                         sels[i], alu_out, carry_out, exps[i]);
            end
        end
    endtask

    task automatic test_wrap;
        apply(1'b0, 8'hFF, 8'h01, 4'd0);
        tests_run++;
        if (alu_out !== 8'h00 || carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_ovf: got out=%h c=%b, want out=00 c=1", alu_out, carry_out);
        end
        apply(1'b0, 8'h00, 8'h01, 4'd1);
        tests_run++;
        if (alu_out !== 8'hFF || carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_borrow: got out=%h c=%b, want out=FF c=1", alu_out, carry_out);
        end
    endtask

    task automatic test_muldiv_edges;
        apply(1'b0, 8'h10, 8'h10, 4'd2);
        tests_run++;
        if (alu_out !== 8'h00 || carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_ovf: got out=%h c=%b, want out=00 c=1", alu_out, carry_out);
        end
        apply(1'b0, 8'h07, 8'h00, 4'd3);
        tests_run++;
        if (alu_out !== 8'hFF || carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_zero: got out=%h c=%b, want out=FF c=1", alu_out, carry_out);
        end
    endtask

    task automatic test_shift_rotate;
        logic [7:0] exps [4] = '{8'h02, 8'h40, 8'h03, 8'hC0};
        logic       expc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 8'h81, 8'h5A, 4'(i + 4));
            tests_run++;
            if (alu_out !== exps[i] || carry_out !== expc[i]) begin
                tests_failed++;
                $display("FAIL shift sel=%0d: got out=%h c=%b, want out=%h c=%b",
                         i + 4, alu_out, carry_out, exps[i], expc[i]);
            end
        end
    endtask

    task automatic test_logic_compare;
        logic [7:0] exps [8] = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'h01, 8'h00};
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 8'hF0, 8'h3C, 4'(i + 8));
            tests_run++;
            if (alu_out !== exps[i] || carry_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL logic sel=%0d: got out=%h c=%b, want out=%h c=0",
                         i + 8, alu_out, carry_out, exps[i]);
            end
        end
        apply(1'b0, 8'h3C, 8'h3C, 4'd15);
        tests_run++;
        if (alu_out !== 8'h01 || carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL eq_equal: got out=%h c=%b, want out=01 c=0", alu_out, carry_out);
        end
    endtask

    task automatic test_reset_midstream;
        apply(1'b0, 8'hC8, 8'h64, 4'd0);
        apply(1'b1, 8'hC8, 8'h64, 4'd0);
        tests_run++;
        if (alu_out !== 8'h00 || carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got out=%h c=%b, want out=00 c=0", alu_out, carry_out);
        end
        apply(1'b0, 8'hC8, 8'h64, 4'd0);
        tests_run++;
        if (alu_out !== 8'h2C || carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset: got out=%h c=%b, want out=2C c=1", alu_out, carry_out);
        end
    endtask

    // Mid-cycle input changes must not disturb the registered result.
    task automatic test_hold;
        apply(1'b0, 8'h12, 8'h34, 4'd9);
        A = 8'h00;
        B = 8'h00;
        alu_sel = 4'd8;
        #3;
        tests_run++;
        if (alu_out !== 8'h36 || carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold: got out=%h c=%b, want out=36 c=0", alu_out, carry_out);
        end
    endtask

    task automatic test_random;
        int a, b, s, eo, ec;
        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 16 == 3) ? 0 : int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 15));
            model(a, b, s, eo, ec);
            apply(1'b0, a[7:0], b[7:0], s[3:0]);
            tests_run++;
            if (alu_out !== eo[7:0] || carry_out !== ec[0]) begin
                tests_failed++;
                $display("FAIL random a=%h b=%h sel=%0d: got out=%h c=%b, want out=%h c=%b",
                         a[7:0], b[7:0], s, alu_out, carry_out, eo[7:0], ec[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A = '0;
        B = '0;
        alu_sel = '0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_muldiv_edges();
        test_shift_rotate();
        test_logic_compare();
        test_reset_midstream();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
